// File: rtl/mem_pkg.sv
// Shared memory map constants for the data RAM and its memory-mapped peripherals.
package mem_pkg;
    localparam int MEM_DEPTH = 100;
    localparam int MEM_AW    = 16;
    localparam int MEM_DW    = 16;

    localparam int SEG_ADDR  = 0;
    localparam int DIOD_ADDR = 1;
    localparam int PWM_ADDR  = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. It gives a one-hot grant to the first eligible index at or after ptr.
// The winner of a cycle gets the lowest priority in the following cycle.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  eligible,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);
    logic [IW-1:0] ptr_q, ptr_d;

    function automatic logic [IW-1:0] idx_of(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_grant && eligible[idx_of(ptr_q, k)]) begin
                any_grant             = 1'b1;
                grant_idx             = idx_of(ptr_q, k);
                grant[idx_of(ptr_q, k)] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (any_grant) ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the RAM read port and write port among NREQ requesters. Each port has its own round-robin
// arbiter. Out-of-range addresses are blocked, and read data goes back to the requester that issued the read.
module ram_port_arbiter
    import mem_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int AW    = MEM_AW,
    parameter int DW    = MEM_DW,
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               addr_err,
    output logic               ram_ro_enable,
    output logic [AW-1:0]      ram_ro_addr,
    input  logic [DW-1:0]      ram_ro_data,
    output logic               ram_wo_enable,
    output logic [AW-1:0]      ram_wo_addr,
    output logic [DW-1:0]      ram_wo_data
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] LIMIT = (AW + 1)'(DEPTH);

    logic [NREQ-1:0] rd_elig, wr_elig, rd_grant, wr_grant;
    logic [IW-1:0]   rd_idx, wr_idx;
    logic            rd_any, wr_any, rd_in, wr_in;
    logic [AW-1:0]   rd_addr, wr_addr;

    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic            rsp_oob_q, rsp_oob_d;
    logic            addr_err_q, addr_err_d;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    // Reset masks eligibility, so nothing is granted and the pointers are not advanced.
    assign rd_elig = reset ? '0 : (req_valid & ~req_write);
    assign wr_elig = reset ? '0 : (req_valid & req_write);

    rr_arbiter #(.N(NREQ)) u_rd_arb (
        .clk(clk), .reset(reset), .eligible(rd_elig),
        .grant(rd_grant), .grant_idx(rd_idx), .any_grant(rd_any)
    );

    rr_arbiter #(.N(NREQ)) u_wr_arb (
        .clk(clk), .reset(reset), .eligible(wr_elig),
        .grant(wr_grant), .grant_idx(wr_idx), .any_grant(wr_any)
    );

    assign rd_addr = req_addr[int'(rd_idx)*AW +: AW];
    assign wr_addr = req_addr[int'(wr_idx)*AW +: AW];
    assign rd_in   = in_range(rd_addr);
    assign wr_in   = in_range(wr_addr);

    assign req_ready     = rd_grant | wr_grant;
    assign ram_ro_enable = rd_any & rd_in;
    assign ram_ro_addr   = rd_addr;
    assign ram_wo_enable = wr_any & wr_in;
    assign ram_wo_addr   = wr_addr;
    assign ram_wo_data   = req_wdata[int'(wr_idx)*DW +: DW];

    // The one-hot read grant, registered, identifies the owner of the response.
    always_comb begin
        rsp_valid_d = rd_grant;
        rsp_oob_d   = rd_any & ~rd_in;
        addr_err_d  = addr_err_q | (rd_any & ~rd_in) | (wr_any & ~wr_in);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_oob_q   <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_oob_q   <= rsp_oob_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_oob_q ? '0 : ram_ro_data;
    assign addr_err  = addr_err_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter. It models a registered-read RAM and checks the arbitration,
// the read latency, the handling of out-of-range addresses and the effect of reset.
module tb_ram_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [31:0] req_addr, req_wdata;
    logic [15:0] rsp_data, ram_ro_addr, ram_ro_data, ram_wo_addr, ram_wo_data;
    logic        addr_err, ram_ro_enable, ram_wo_enable;

    logic        pl_en;
    logic [6:0]  pl_addr;
    logic [15:0] pl_data;
    logic [15:0] mem [0:127];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .addr_err(addr_err),
        .ram_ro_enable(ram_ro_enable), .ram_ro_addr(ram_ro_addr), .ram_ro_data(ram_ro_data),
        .ram_wo_enable(ram_wo_enable), .ram_wo_addr(ram_wo_addr), .ram_wo_data(ram_wo_data)
    );

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_wo_enable) mem[ram_wo_addr[6:0]] <= ram_wo_data;
        if (ram_ro_enable) ram_ro_data <= mem[ram_ro_addr[6:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w,
                         input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] d1);
        req_valid = v;
        req_write = w;
        req_addr  = {a1, a0};
        req_wdata = {d1, 16'h0000};
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        req_valid = 2'b11; req_write = 2'b00; req_addr = '0; req_wdata = '0;

        // Reset is held for three cycles with both requesters active. The first two cycles preload the RAM.
        next_cycle(); pl_en = 1'b1; pl_addr = 7'd5; pl_data = 16'h1234;
        next_cycle(); pl_addr = 7'd7; pl_data = 16'h00AA;
        next_cycle(); pl_en = 1'b0;
        #2;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_ro_en", ram_ro_enable, 1'b0);
        chk("rst_wo_en", ram_wo_enable, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_addr_err", addr_err, 1'b0);
        next_cycle(); reset = 1'b0;

        // Single read
        drive(2'b01, 2'b00, 16'd5, 16'd0, 16'h0);
        chk("single_ready", req_ready, 2'b01);
        chk("single_ro_en", ram_ro_enable, 1'b1);
        chk("single_ro_addr", ram_ro_addr, 16'd5);
        next_cycle(); drive(2'b00, 2'b00, 16'd0, 16'd0, 16'h0);
        chk("single_rsp_valid", rsp_valid, 2'b01);
        chk("single_rsp_data", rsp_data, 16'h1234);

        // Contention after a fresh reset
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0;
        drive(2'b11, 2'b00, 16'd5, 16'd7, 16'h0);
        chk("cont_g0", req_ready, 2'b01);
        next_cycle(); #2;
        chk("cont_g1", req_ready, 2'b10);
        chk("cont_r0_valid", rsp_valid, 2'b01);
        chk("cont_r0_data", rsp_data, 16'h1234);
        next_cycle(); #2;
        chk("cont_g2", req_ready, 2'b01);
        chk("cont_r1_valid", rsp_valid, 2'b10);
        chk("cont_r1_data", rsp_data, 16'h00AA);
        next_cycle(); #2;
        chk("cont_g3", req_ready, 2'b10);
        chk("cont_r2_valid", rsp_valid, 2'b01);
        next_cycle(); drive(2'b00, 2'b00, 16'd0, 16'd0, 16'h0);
        chk("cont_r3_valid", rsp_valid, 2'b10);

        // Parallel read and write to address 7. The read must return the old value.
        next_cycle(); drive(2'b11, 2'b10, 16'd7, 16'd7, 16'h5555);
        chk("par_ready", req_ready, 2'b11);
        chk("par_ro_en", ram_ro_enable, 1'b1);
        chk("par_wo_en", ram_wo_enable, 1'b1);
        chk("par_wo_addr", ram_wo_addr, 16'd7);
        chk("par_wo_data", ram_wo_data, 16'h5555);
        next_cycle(); drive(2'b00, 2'b00, 16'd0, 16'd0, 16'h0);
        chk("par_rsp_valid", rsp_valid, 2'b01);
        chk("par_rsp_old", rsp_data, 16'h00AA);
        next_cycle(); drive(2'b10, 2'b00, 16'd0, 16'd7, 16'h0);
        chk("par_reread_ready", req_ready, 2'b10);
        next_cycle(); drive(2'b00, 2'b00, 16'd0, 16'd0, 16'h0);
        chk("par_reread_valid", rsp_valid, 2'b10);
        chk("par_reread_data", rsp_data, 16'h5555);

        // Out-of-range write, then out-of-range read
        chk("pre_oob_addr_err", addr_err, 1'b0);
        next_cycle(); drive(2'b10, 2'b10, 16'd0, 16'd100, 16'hBEEF);
        chk("oobw_ready", req_ready, 2'b10);
        chk("oobw_wo_en", ram_wo_enable, 1'b0);
        next_cycle(); drive(2'b10, 2'b00, 16'd0, 16'd200, 16'h0);
        chk("oobw_addr_err", addr_err, 1'b1);
        chk("oobr_ready", req_ready, 2'b10);
        chk("oobr_ro_en", ram_ro_enable, 1'b0);
        next_cycle(); drive(2'b00, 2'b00, 16'd0, 16'd0, 16'h0);
        chk("oobr_rsp_valid", rsp_valid, 2'b10);
        chk("oobr_rsp_data", rsp_data, 16'h0000);
        chk("oobr_addr_err", addr_err, 1'b1);

        // The last valid address is still in range.
        next_cycle(); drive(2'b01, 2'b00, 16'd99, 16'd0, 16'h0);
        chk("edge99_ro_en", ram_ro_enable, 1'b1);
        next_cycle(); drive(2'b00, 2'b00, 16'd0, 16'd0, 16'h0);
        chk("edge99_rsp_valid", rsp_valid, 2'b01);
        chk("sticky_addr_err", addr_err, 1'b1);

        // Reset is asserted in the grant cycle of a read. The read pointer sits at 1 beforehand.
        next_cycle(); reset = 1'b1; drive(2'b01, 2'b00, 16'd5, 16'd0, 16'h0);
        chk("rstmid_ready", req_ready, 2'b00);
        chk("rstmid_ro_en", ram_ro_enable, 1'b0);
        next_cycle(); reset = 1'b0; #2;
        chk("rstmid_rsp_valid", rsp_valid, 2'b00);
        chk("rstmid_addr_err", addr_err, 1'b0);
        drive(2'b11, 2'b00, 16'd5, 16'd7, 16'h0);
        chk("rstmid_ptr0", req_ready, 2'b01);
        next_cycle(); drive(2'b00, 2'b00, 16'd0, 16'd0, 16'h0);
        chk("rstmid_after_valid", rsp_valid, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
